// File: rtl/ct_pkg.sv
// Shared definitions for the cut-through interconnect nodes (split, merge, pipe).
// Holds the state encoding, index-width helpers and the end-of-packet extractor.
package ct_pkg;

    localparam logic CT_ST_IDLE   = 1'b0;
    localparam logic CT_ST_LOCKED = 1'b1;

    // Widest data word the eop helper accepts; callers zero-extend into it.
    localparam int CT_MAX_W = 1024;

    typedef enum logic {
        ST_IDLE   = CT_ST_IDLE,
        ST_LOCKED = CT_ST_LOCKED
    } ct_state_e;

    function automatic int ct_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A single input still needs a 1-bit index.
    function automatic int ct_idx_w(input int n);
        return (n <= 1) ? 1 : ct_clog2(n);
    endfunction

    function automatic logic ct_get_eop(input logic [CT_MAX_W-1:0] word,
                                        input logic [9:0]          loc);
        return word[loc];
    endfunction

endpackage

// File: rtl/ct_merge_oreg.sv
// Two-entry skid buffer placed on the ct_merge output when CT_MERGE_OUTREG_EN is defined.
// The upstream ready depends only on the fill count, never on the downstream ready.
module ct_merge_oreg
    import ct_pkg::*;
#(
    parameter int WO = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [WO-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [WO-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
);

    logic [1:0]    r_cnt;
    logic [WO-1:0] r_head;
    logic [WO-1:0] r_tail;
    logic          w_push;
    logic          w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    // r_head is always the oldest beat; r_tail only fills while the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ct_merge.sv
// N-to-1 round-robin merge node that holds its grant until end-of-packet.
// Define CT_MERGE_OUTREG_EN to register the output through a 2-entry skid buffer.
module ct_merge
    import ct_pkg::*;
#(
    parameter int NI      = 2,
    parameter int WO      = 32,
    parameter int EOP_LOC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NI*WO-1:0] i_data,
    input  logic [NI-1:0]    i_valid,
    output logic [NI-1:0]    o_ready,
    output logic [WO-1:0]    o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int IW = ct_idx_w(NI);

    ct_state_e     r_st;
    ct_state_e     w_stNext;
    logic [IW-1:0] r_g;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_gNext;
    logic [IW-1:0] w_lastNext;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_sel;
    logic          w_anyValid;
    logic          w_inValid;
    logic          w_arbValid;
    logic          w_dsReady;
    logic          w_xfer;
    logic          w_eop;
    logic [WO-1:0] w_arbData;
    int            w_bestDist;

    // Winner is the valid input closest after r_last in circular order.
    always_comb begin
        w_win      = '0;
        w_anyValid = 1'b0;
        w_bestDist = NI;
        for (int k = 0; k < NI; k++) begin
            if (i_valid[k] && (((k + NI - 1 - int'(r_last)) % NI) < w_bestDist)) begin
                w_bestDist = (k + NI - 1 - int'(r_last)) % NI;
                w_win      = IW'(k);
                w_anyValid = 1'b1;
            end
        end
    end

    assign w_sel = (r_st == ST_LOCKED) ? r_g : w_win;

    always_comb begin
        w_arbData = i_data[WO-1:0];
        w_inValid = i_valid[0];
        for (int k = 1; k < NI; k++) begin
            if (w_sel == IW'(k)) begin
                w_arbData = i_data[k*WO +: WO];
                w_inValid = i_valid[k];
            end
        end
    end

    assign w_arbValid = ~reset & w_inValid;
    assign w_xfer     = w_arbValid & w_dsReady;
    assign w_eop      = ct_get_eop(CT_MAX_W'(w_arbData), 10'(EOP_LOC));

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            o_ready[k] = ~reset & w_dsReady & (w_sel == IW'(k));
        end
    end

`ifdef CT_MERGE_OUTREG_EN
    ct_merge_oreg #(
        .WO(WO)
    ) u_oreg (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_arbData),
        .i_valid (w_arbValid),
        .o_ready (w_dsReady),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );
`else
    assign w_dsReady = i_ready;
    assign o_data    = w_arbData;
    assign o_valid   = w_arbValid;
`endif

    // An offer that is stalled or not yet at eop locks the winner so it cannot be stolen.
    always_comb begin
        w_stNext   = r_st;
        w_gNext    = r_g;
        w_lastNext = r_last;
        case (r_st)
            ST_IDLE: begin
                if (w_anyValid) begin
                    if (w_xfer && w_eop) begin
                        w_lastNext = w_win;
                    end else begin
                        w_stNext = ST_LOCKED;
                        w_gNext  = w_win;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_eop) begin
                    w_stNext   = ST_IDLE;
                    w_lastNext = r_g;
                end
            end
            default: w_stNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st   <= ST_IDLE;
            r_g    <= '0;
            r_last <= IW'(NI - 1);
        end else begin
            r_st   <= w_stNext;
            r_g    <= w_gNext;
            r_last <= w_lastNext;
        end
    end

endmodule
